hood_mode_controller: RTL

//  Top-level mode sequencer for the exhaust hood. Decodes one-cycle button pulses into the

---
 rtl/hood_mode_controller_if.sv | 31 +++
 rtl/hood_mode_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hood_mode_controller_if.sv
// Button pulses into, and mode/timer status out of, the hood mode sequencer.
`default_nettype none

interface hood_mode_controller_if #(
    parameter int MODE_WIDTH = 3,
    parameter int TIME_WIDTH = 8
);
    logic                  power_btn;
    logic                  standby_btn;
    logic                  mode1_btn;
    logic                  mode2_btn;
    logic                  mode3_btn;
    logic                  clean_btn;
    logic [MODE_WIDTH-1:0] current_mode;
    logic [TIME_WIDTH-1:0] remaining_sec;
    logic                  hurricane_used;
    logic                  fan_on;
    logic                  clean_done;

    modport master (
        output power_btn, standby_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn,
        input  current_mode, remaining_sec, hurricane_used, fan_on, clean_done
    );

    modport slave (
        input  power_btn, standby_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn,
        output current_mode, remaining_sec, hurricane_used, fan_on, clean_done
    );
endinterface

`default_nettype wire

// File: rtl/hood_mode_controller.sv
// Exhaust hood mode sequencer: decodes button pulses into current_mode and owns the
// hurricane, exit-delay and self-clean timers.
`default_nettype none

module hood_mode_controller #(
    parameter int MODE_WIDTH    = 3,
    parameter int TIME_WIDTH    = 8,
    parameter int COUNTER_1SEC  = 100000000,
    parameter int HURRICANE_SEC = 60,
    parameter int EXIT_SEC      = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  wire logic              clk,
    input  wire logic              rst,
    hood_mode_controller_if.slave  bus
);
    localparam int PS_W = (COUNTER_1SEC > 1) ? $clog2(COUNTER_1SEC) : 1;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_FIRST   = 3'd2,
        ST_SECOND  = 3'd3,
        ST_THIRD   = 3'd4,
        ST_EXIT    = 3'd5,
        ST_CLEAN   = 3'd6,
        ST_UNUSED  = 3'd7
    } mode_t;

    typedef enum logic [2:0] {
        BTN_NONE, BTN_POWER, BTN_CLEAN, BTN_MODE3, BTN_MODE2, BTN_MODE1, BTN_STANDBY
    } btn_t;

    mode_t                 state;
    mode_t                 next_state;
    btn_t                  winner;
    logic                  next_done;
    logic                  tick;
    logic                  last_sec;
    logic [PS_W-1:0]       prescaler;
    logic [TIME_WIDTH-1:0] remaining;
    logic                  used;
    logic                  fan;
    logic                  done;

    function automatic logic is_timed(input mode_t m);
        return (m == ST_THIRD) || (m == ST_EXIT) || (m == ST_CLEAN);
    endfunction

    function automatic logic [TIME_WIDTH-1:0] load_value(input mode_t m);
        case (m)
            ST_THIRD: return TIME_WIDTH'(HURRICANE_SEC);
            ST_EXIT:  return TIME_WIDTH'(EXIT_SEC);
            ST_CLEAN: return TIME_WIDTH'(CLEAN_SEC);
            default:  return '0;
        endcase
    endfunction

    // Only the highest-priority pulse is ever considered by the state logic.
    always_comb begin
        winner = BTN_NONE;
        if      (bus.power_btn)   winner = BTN_POWER;
        else if (bus.clean_btn)   winner = BTN_CLEAN;
        else if (bus.mode3_btn)   winner = BTN_MODE3;
        else if (bus.mode2_btn)   winner = BTN_MODE2;
        else if (bus.mode1_btn)   winner = BTN_MODE1;
        else if (bus.standby_btn) winner = BTN_STANDBY;
    end

    assign tick     = (prescaler == PS_W'(COUNTER_1SEC - 1));
    assign last_sec = tick && (remaining == TIME_WIDTH'(1));

    always_comb begin
        next_state = state;
        next_done  = 1'b0;
        case (state)
            ST_OFF: begin
                if (winner == BTN_POWER) next_state = ST_STANDBY;
            end
            ST_STANDBY, ST_FIRST, ST_SECOND: begin
                case (winner)
                    BTN_POWER:   next_state = ST_OFF;
                    BTN_CLEAN:   if (state == ST_STANDBY) next_state = ST_CLEAN;
                    BTN_MODE3:   if (!used) next_state = ST_THIRD;
                    BTN_MODE2:   next_state = ST_SECOND;
                    BTN_MODE1:   next_state = ST_FIRST;
                    BTN_STANDBY: next_state = ST_STANDBY;
                    default:     next_state = state;
                endcase
            end
            ST_THIRD: begin
                if (winner == BTN_POWER || winner == BTN_STANDBY) next_state = ST_EXIT;
                else if (last_sec)                                 next_state = ST_SECOND;
            end
            ST_EXIT: begin
                if (winner == BTN_POWER) next_state = ST_OFF;
                else if (last_sec)       next_state = ST_STANDBY;
            end
            ST_CLEAN: begin
                if (winner == BTN_POWER) begin
                    next_state = ST_OFF;
                end else if (last_sec) begin
                    next_state = ST_STANDBY;
                    next_done  = 1'b1;
                end
            end
            default: next_state = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            remaining <= '0;
            prescaler <= '0;
            used      <= 1'b0;
            fan       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            fan   <= (next_state inside {ST_FIRST, ST_SECOND, ST_THIRD, ST_EXIT, ST_CLEAN});
            done  <= next_done;

            if (next_state == ST_OFF)        used <= 1'b0;
            else if (next_state == ST_THIRD) used <= 1'b1;

            // A timed state that is still held here always has remaining >= 2 at a tick.
            if (next_state != state) begin
                remaining <= load_value(next_state);
                prescaler <= '0;
            end else if (is_timed(state)) begin
                if (tick) begin
                    prescaler <= '0;
                    remaining <= remaining - TIME_WIDTH'(1);
                end else begin
                    prescaler <= prescaler + PS_W'(1);
                end
            end else begin
                remaining <= '0;
                prescaler <= '0;
            end
        end
    end

    assign bus.current_mode   = MODE_WIDTH'(state);
    assign bus.remaining_sec  = remaining;
    assign bus.hurricane_used = used;
    assign bus.fan_on         = fan;
    assign bus.clean_done     = done;

endmodule

`default_nettype wire
